spi_register_write_sink: RTL and testbench
==========================================

// Module: spi_register_write_sink
// PURPOSE
//   Write-direction SPI register endpoint: counterpart to the read-only register responders.
//   Receives the bytes the SPI peripheral delivers for a selected register, entirely in the
//   system_clock domain, and buffers the whole transaction as one payload.
//   On transaction end, presents the payload to system logic over a valid/ready handshake.
//   Sits between the SPI peripheral address decode and the consuming function block (e.g. display, camera).
// PARAMETERS
//   MAX_BYTES    16  payload buffer depth in bytes; bytes beyond this are discarded
//   SYNC_STAGES  2   synchronizer depth for enable/data_in_valid (min 2)
// PORTS
//   system_clock      in   1              system clock; all logic on posedge
//   reset             in   1              asynchronous, active-high reset
//   enable            in   1              SPI domain; high while this register is selected
//   data_in_valid     in   1              SPI domain; high while data_in holds a received byte
//   data_in           in   8              SPI domain; stable whenever data_in_valid is high
//   payload_data      out  8*MAX_BYTES    byte k at [8k+7:8k]; byte 0 = first received
//   payload_length    out  $clog2(MAX_BYTES+1)  bytes stored, saturates at MAX_BYTES
//   payload_overflow  out  1              >MAX_BYTES bytes arrived in this transaction
//   payload_valid     out  1              payload fields valid; held until accepted
//   payload_ready     in   1              consumer accepts when valid && ready
//   payload_dropped   out  1              1-cycle pulse: transaction discarded, consumer busy
// BEHAVIOUR
//   - Reset: all outputs 0, buffer 0, state IDLE, synchronizer flops 0; asynchronous assert.
//   - enable, data_in_valid pass through SYNC_STAGES flops, then a 1-flop edge detector.
//     Byte capture occurs SYNC_STAGES+1 cycles after raw data_in_valid rises.
//     data_in is sampled raw on the capture cycle. The sender guarantees stability, so no sync is needed.
//   - States: IDLE, RECEIVE, COMMIT.
//     IDLE   : synced enable rise -> RECEIVE; clear count, overflow flag and buffer.
//     RECEIVE: each synced data_in_valid rise stores data_in at index count.
//              If count < MAX_BYTES: count++. Otherwise: byte dropped, overflow flag set.
//              synced enable fall with count>0 -> COMMIT.
//              synced enable fall with count==0 -> IDLE; no payload is produced.
//     COMMIT : payload_valid=1; payload_* held constant.
//              On valid && ready: payload_valid drops the next cycle -> IDLE.
//   - Latency: payload_valid rises 1 cycle after the synced enable falling edge is detected.
//   - Same-cycle events:
//     - data_in_valid rise and enable fall detected together: the byte is stored first, then COMMIT.
//     - data_in_valid rise while synced enable is low: ignored.
//   - Enable rise while in COMMIT: that whole transaction is ignored.
//     payload_dropped pulses once on the rise; current payload is unaffected.
//     The FSM stays ignoring until that enable falls.
//   - payload_ready while payload_valid=0: no effect.
//   - Reset mid-transaction or mid-COMMIT: payload is lost; no valid pulse follows.
//   - Counter is width $clog2(MAX_BYTES+1); it never wraps.
// STRUCTURE
//   - Package spi_register_pkg:
//     - typedef enum logic [1:0] {IDLE, RECEIVE, COMMIT} write_sink_state_t;
//     - localparam BYTE_WIDTH = 8.
//   - Sub-module spi_sync_edge, instantiated twice (enable, data_in_valid).
//     Parameter SYNC_STAGES; outputs synced level, rise pulse, fall pulse; async reset.
//   - Top level: FSM, byte counter, buffer write-enable decode, handshake register.
// TESTING
//   1. Write 0x12,0x34,0x56 then drop enable.
//      -> valid with length=3, data[23:0]=0x563412, overflow=0.
//      Ready held high -> valid lasts exactly 1 cycle.
//   2. Write MAX_BYTES+2 bytes (0x00..0x11).
//      -> length=16, overflow=1, byte 15 = 0x0F; 0x10 and 0x11 are absent.
//   3. Enable pulse with no bytes.
//      -> payload_valid never rises; state returns to IDLE.
//   4. Ready held low after txn A (0xAA); send txn B (0xBB).
//      -> payload_dropped pulses once; payload remains 0xAA.
//      Raise ready -> accepted; txn C (0xCC) then commits normally.
//   5. Assert reset after 2 of 4 bytes, then deassert.
//      -> all outputs 0 immediately; no payload_valid; next full txn commits correctly.
//   6. Raw data_in_valid rise 1 cycle before raw enable fall.
//      -> byte stored, included in length; valid follows.

Source files
------------

// File: rtl/spi_register_pkg.sv
// rtl/spi_register_pkg.sv - shared types for the SPI register write sink
package spi_register_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECEIVE,
        COMMIT
    } write_sink_state_t;

    localparam int BYTE_WIDTH = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall pulse detection
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic system_clock,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_register_write_sink.sv
// rtl/spi_register_write_sink.sv - buffers one SPI write transaction and hands it off via valid/ready
module spi_register_write_sink
    import spi_register_pkg::*;
#(
    parameter int MAX_BYTES   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                              system_clock,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              data_in_valid,
    input  logic [BYTE_WIDTH-1:0]             data_in,
    output logic [BYTE_WIDTH*MAX_BYTES-1:0]   payload_data,
    output logic [$clog2(MAX_BYTES+1)-1:0]    payload_length,
    output logic                              payload_overflow,
    output logic                              payload_valid,
    input  logic                              payload_ready,
    output logic                              payload_dropped
);

    localparam int COUNT_W = $clog2(MAX_BYTES+1);

    logic w_en_level, w_en_rise, w_en_fall;
    logic w_dv_level, w_dv_rise, w_dv_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_enable (
        .system_clock (system_clock),
        .reset        (reset),
        .i_async      (enable),
        .o_level      (w_en_level),
        .o_rise       (w_en_rise),
        .o_fall       (w_en_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data_valid (
        .system_clock (system_clock),
        .reset        (reset),
        .i_async      (data_in_valid),
        .o_level      (w_dv_level),
        .o_rise       (w_dv_rise),
        .o_fall       (w_dv_fall)
    );

    write_sink_state_t                r_state;
    logic [COUNT_W-1:0]               r_count;
    logic                             r_overflow;
    logic [BYTE_WIDTH*MAX_BYTES-1:0]  r_buffer;
    logic                             r_valid;
    logic                             r_dropped;
    logic                             r_ignore;

    logic                  w_store;
    logic                  w_room;
    logic [COUNT_W-1:0]    w_count_next;
    logic [MAX_BYTES-1:0]  w_byte_we;
    logic                  w_unused;

    // A byte arriving in the same cycle as the enable fall still belongs to this transaction.
    assign w_store      = (r_state == RECEIVE) && w_dv_rise && w_dv_level && (w_en_level || w_en_fall);
    assign w_room       = (r_count < COUNT_W'(MAX_BYTES));
    assign w_count_next = r_count + COUNT_W'(w_store && w_room);
    assign w_unused     = w_dv_fall;

    always_comb begin
        w_byte_we = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            w_byte_we[k] = w_store && w_room && (r_count == COUNT_W'(k));
        end
    end

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_buffer   <= '0;
            r_valid    <= 1'b0;
            r_dropped  <= 1'b0;
            r_ignore   <= 1'b0;
        end else begin
            r_dropped <= 1'b0;
            if (w_en_fall) begin
                r_ignore <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_en_rise && !r_ignore) begin
                        r_state    <= RECEIVE;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_buffer   <= '0;
                    end
                end
                RECEIVE: begin
                    for (int k = 0; k < MAX_BYTES; k++) begin
                        if (w_byte_we[k]) begin
                            r_buffer[k*BYTE_WIDTH +: BYTE_WIDTH] <= data_in;
                        end
                    end
                    if (w_store && !w_room) begin
                        r_overflow <= 1'b1;
                    end
                    r_count <= w_count_next;
                    if (w_en_fall) begin
                        if (w_count_next != '0) begin
                            r_state <= COMMIT;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                COMMIT: begin
                    if (r_valid && payload_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                    // A new selection while the consumer is still busy is dropped whole.
                    if (w_en_rise) begin
                        r_dropped <= 1'b1;
                        r_ignore  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign payload_data     = r_buffer;
    assign payload_length   = r_count;
    assign payload_overflow = r_overflow;
    assign payload_valid    = r_valid;
    assign payload_dropped  = r_dropped;

endmodule

// File: tb/tb_spi_register_write_sink.sv
// tb/tb_spi_register_write_sink.sv - scoreboard bench for spi_register_write_sink
module tb_spi_register_write_sink;

    localparam int MAX_BYTES = 16;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [127:0] data;
        int           len;
        logic         ovf;
    } exp_t;

    logic         system_clock = 1'b0;
    logic         reset;
    logic         enable;
    logic         data_in_valid;
    logic [7:0]   data_in;
    logic [127:0] payload_data;
    logic [4:0]   payload_length;
    logic         payload_overflow;
    logic         payload_valid;
    logic         payload_ready;
    logic         payload_dropped;

    spi_register_write_sink #(.MAX_BYTES(MAX_BYTES), .SYNC_STAGES(2)) dut (
        .system_clock     (system_clock),
        .reset            (reset),
        .enable           (enable),
        .data_in_valid    (data_in_valid),
        .data_in          (data_in),
        .payload_data     (payload_data),
        .payload_length   (payload_length),
        .payload_overflow (payload_overflow),
        .payload_valid    (payload_valid),
        .payload_ready    (payload_ready),
        .payload_dropped  (payload_dropped)
    );

    always #5 system_clock = ~system_clock;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   drop_count = 0;
    int   valid_rises = 0;
    int   run_len = 0;
    int   last_valid_len = 0;
    logic prev_valid = 1'b0;
    bit   rand_ready = 1'b0;
    exp_t mon_e;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge system_clock);
        #2;
    endtask

    function automatic exp_t model(input bq_t b);
        exp_t e;
        e.data = '0;
        e.len  = (b.size() > MAX_BYTES) ? MAX_BYTES : b.size();
        e.ovf  = (b.size() > MAX_BYTES);
        for (int i = 0; i < b.size() && i < MAX_BYTES; i++) e.data[i*8 +: 8] = b[i];
        return e;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        data_in = b;
        data_in_valid = 1'b1;
        repeat (3) tick();
        data_in_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic txn(input bq_t b, input bit expect_it);
        if (expect_it && b.size() > 0) exp_q.push_back(model(b));
        enable = 1'b1;
        repeat (4) tick();
        foreach (b[i]) send_byte(b[i]);
        enable = 1'b0;
        repeat (6) tick();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
    endtask

    always @(posedge system_clock) begin
        if (rand_ready) begin
            #2;
            payload_ready = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge system_clock) begin
        if (reset) begin
            run_len = 0;
            prev_valid = 1'b0;
        end else begin
            if (payload_dropped) drop_count++;
            if (payload_valid && !prev_valid) valid_rises++;
            if (payload_valid) run_len++;
            else if (run_len > 0) begin
                last_valid_len = run_len;
                run_len = 0;
            end
            if (payload_valid && payload_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_payload: got len %0d data %0h, expected no payload",
                             payload_length, payload_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("payload_data", payload_data, mon_e.data);
                    check("payload_length", 128'(payload_length), 128'(mon_e.len));
                    check("payload_overflow", 128'(payload_overflow), 128'(mon_e.ovf));
                end
            end
            prev_valid = payload_valid;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bq_t b;
        int  r;
        int  d0;
        reset = 1'b1;
        enable = 1'b0;
        data_in_valid = 1'b0;
        data_in = 8'h00;
        payload_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", 128'(payload_valid), 0);
        check("rst_length", 128'(payload_length), 0);
        check("rst_overflow", 128'(payload_overflow), 0);
        check("rst_data", payload_data, 0);
        check("rst_dropped", 128'(payload_dropped), 0);
        reset = 1'b0;
        tick();

        b = '{8'h12, 8'h34, 8'h56};
        txn(b, 1'b1);
        wait_drain("t1");
        repeat (3) tick();
        check("t1_valid_len", 128'(last_valid_len), 1);

        b = {};
        for (int i = 0; i < MAX_BYTES + 2; i++) b.push_back(8'(i));
        txn(b, 1'b1);
        wait_drain("t2");

        r = valid_rises;
        enable = 1'b1;
        repeat (6) tick();
        enable = 1'b0;
        repeat (10) tick();
        check("t3_no_valid", 128'(valid_rises), 128'(r));
        check("t3_valid_low", 128'(payload_valid), 0);

        payload_ready = 1'b0;
        d0 = drop_count;
        b = '{8'hAA};
        txn(b, 1'b1);
        check("t4_valid_held", 128'(payload_valid), 1);
        b = '{8'hBB};
        txn(b, 1'b0);
        check("t4_dropped", 128'(drop_count - d0), 1);
        check("t4_hold_data", 128'(payload_data[7:0]), 128'h AA);
        check("t4_hold_len", 128'(payload_length), 1);
        check("t4_still_valid", 128'(payload_valid), 1);
        payload_ready = 1'b1;
        wait_drain("t4a");
        b = '{8'hCC};
        txn(b, 1'b1);
        wait_drain("t4c");

        enable = 1'b1;
        repeat (4) tick();
        send_byte(8'h11);
        send_byte(8'h22);
        #1;
        reset = 1'b1;
        #1;
        check("t5_valid", 128'(payload_valid), 0);
        check("t5_length", 128'(payload_length), 0);
        check("t5_data", payload_data, 0);
        check("t5_overflow", 128'(payload_overflow), 0);
        enable = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        r = valid_rises;
        repeat (10) tick();
        check("t5_no_valid", 128'(valid_rises), 128'(r));
        b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        txn(b, 1'b1);
        wait_drain("t5");

        b = '{8'h5A, 8'h77};
        exp_q.push_back(model(b));
        enable = 1'b1;
        repeat (4) tick();
        send_byte(8'h5A);
        data_in = 8'h77;
        data_in_valid = 1'b1;
        tick();
        enable = 1'b0;
        repeat (3) tick();
        data_in_valid = 1'b0;
        repeat (6) tick();
        wait_drain("t6a");

        b = '{8'h33};
        exp_q.push_back(model(b));
        enable = 1'b1;
        repeat (4) tick();
        data_in = 8'h33;
        data_in_valid = 1'b1;
        enable = 1'b0;
        repeat (3) tick();
        data_in_valid = 1'b0;
        repeat (6) tick();
        wait_drain("t6b");

        rand_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            int n;
            n = $urandom_range(0, 20);
            b = {};
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            txn(b, 1'b1);
            wait_drain("rand");
        end
        rand_ready = 1'b0;
        tick();
        payload_ready = 1'b1;
        repeat (5) tick();
        check("total_dropped", 128'(drop_count), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
